ysyx_22041207_axi_rd_bridge: RTL
================================

Name: ysyx_22041207_axi_rd_bridge

Overview:
- Responder on the arbitrated single read port driven by the IF/MEM read switch.
- Accepts one simple read request (valid/ready, addr, size), issues a single-beat AXI4 AR transaction, and collects the R beat.
- Returns byte-aligned, zero-extended data to the switch with a valid/ready handshake.
- Sits between the read switch and the AXI interconnect/memory model. Strictly one outstanding transaction.

Parameters:
- RW_DATA_WIDTH, 64, upstream data width.
- RW_ADDR_WIDTH, 64, upstream address width.
- AXI_DATA_WIDTH, 64, AXI R data width; must equal RW_DATA_WIDTH.
- AXI_ADDR_WIDTH, 64, AXI AR address width.
- AXI_ID_WIDTH, 4, ARID width.
- AXI_USER_WIDTH, 1, ARUSER width.
- AXI_ID, 0, constant ARID value; RID is checked against it.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- rw_valid_i  in  1  upstream request valid
- rw_ready_o  out  1  bridge accepts request
- rw_addr_i  in  RW_ADDR_WIDTH  byte address
- rw_size_i  in  8  byte count: 1, 2, 4 or 8
- rw_data_o  out  RW_DATA_WIDTH  aligned, zero-extended read data
- rw_data_valid_o  out  1  rw_data_o valid
- rw_data_ready_i  in  1  upstream consumed data
- rw_resp_err_o  out  1  RRESP != OKAY or RID mismatch; qualified by rw_data_valid_o
- axi_ar_valid_o  out  1  ARVALID
- axi_ar_ready_i  in  1  ARREADY
- axi_ar_addr_o  out  AXI_ADDR_WIDTH  ARADDR (unaligned address passed through)
- axi_ar_id_o  out  AXI_ID_WIDTH  ARID = AXI_ID
- axi_ar_len_o  out  8  ARLEN, constant 0
- axi_ar_size_o  out  3  ARSIZE
- axi_ar_burst_o  out  2  ARBURST, constant 2'b01 (INCR)
- axi_ar_user_o  out  AXI_USER_WIDTH  constant 0
- axi_r_valid_i  in  1  RVALID
- axi_r_ready_o  out  1  RREADY
- axi_r_data_i  in  AXI_DATA_WIDTH  RDATA
- axi_r_resp_i  in  2  RRESP
- axi_r_id_i  in  AXI_ID_WIDTH  RID
- axi_r_last_i  in  1  RLAST, ignored; single beat

Behaviour:
- FSM states: IDLE, AR, R, DONE.
- Reset (rst_n low at a clock edge): state IDLE, all registered outputs 0. rw_ready_o is 1 only in IDLE, so it is 1 on the first cycle after reset. Reset mid-transaction aborts immediately with no completion to upstream.
- IDLE:
  - rw_ready_o=1.
  - On rw_valid_i=1, capture addr and size into registers and go to AR.
  - Upstream inputs are not sampled again until the next IDLE.
- AR:
  - axi_ar_valid_o=1. ARADDR/ARSIZE come from the captured registers and stay stable while ARVALID is high.
  - Go to R on axi_ar_ready_i=1.
  - ARVALID never drops without ARREADY.
- R:
  - axi_r_ready_o=1.
  - On axi_r_valid_i=1, capture the shifted and masked data plus the error flag, then go to DONE.
- DONE:
  - rw_data_valid_o=1; data and err held stable.
  - On rw_data_ready_i=1, go to IDLE.
  - rw_data_ready_i is ignored in all other states.
- ARSIZE mapping: size 1→0, 2→1, 4→2, 8→3. Any other value → 3; the read is treated as 8 bytes.
- Data alignment:
  - shifted = RDATA >> (addr[2:0]*8).
  - Keep the low size*8 bits; upper bits are 0.
  - No sign extension; that belongs to the consumer.
  - An access crossing an 8-byte boundary returns only the bytes inside the beat; no split.
- rw_resp_err_o = (RRESP != 2'b00) || (RID != AXI_ID). Data is still returned on error.
- Latency:
  - Request accepted at edge N → ARVALID high in cycle N+1.
  - With zero-wait AR and R, rw_data_valid_o is high in cycle N+3.
  - Each AR/R wait cycle adds 1.
- Back-to-back: the earliest next acceptance is the cycle after the DONE handshake (rw_ready_o returns in IDLE). Throughput is at most 1 read per 4 cycles.
- An R beat arriving while in AR (RVALID before the AR handshake) is ignored: RREADY is 0 there.

Test Plan:
- Aligned 8-byte read: addr 0x80000000, size 8, ARREADY immediate, RDATA 0x1122334455667788 in the next cycle → ARSIZE=3, ARLEN=0, ARBURST=1; rw_data_o=0x1122334455667788 with data_valid 3 cycles after accept; err=0.
- Sub-word: addr 0x80000005, size 2, RDATA 0x1122334455667788 → ARSIZE=1, rw_data_o=0x0000000000002233. Then size 1 at addr 0x80000007 → 0x11.
- Backpressure: ARREADY delayed 3 cycles, RVALID delayed 2 cycles, rw_data_ready_i held low 4 cycles → ARVALID, ARADDR and rw_data_o stay stable throughout; exactly one AR handshake; return to IDLE only after the ready handshake.
- Error: RRESP=2'b10 → rw_resp_err_o=1 with data returned; RID≠AXI_ID → err=1.
- Reset mid-op: assert rst_n=0 in state R → next cycle ARVALID=RREADY=data_valid=0 and rw_ready_o=1 after release; a new request completes normally.
- Back-to-back: rw_valid_i held high for two requests, 0x100 (size 4) then 0x108 (size 8) → two sequential AR transactions; the second accept happens the cycle after the first DONE handshake; data is correct per address.

Source files
------------

// File: rtl/ysyx_22041207_axi_rd_bridge.sv
// Single-outstanding read bridge: one upstream read request becomes one single-beat AXI4 AR/R
// transaction, and the result comes back byte-aligned and zero-extended.
module ysyx_22041207_axi_rd_bridge #(
    parameter int RW_DATA_WIDTH  = 64,
    parameter int RW_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int AXI_ID         = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      rw_valid_i,
    output logic                      rw_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0]  rw_addr_i,
    input  logic [7:0]                rw_size_i,
    output logic [RW_DATA_WIDTH-1:0]  rw_data_o,
    output logic                      rw_data_valid_o,
    input  logic                      rw_data_ready_i,
    output logic                      rw_resp_err_o,

    output logic                      axi_ar_valid_o,
    input  logic                      axi_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
    output logic [7:0]                axi_ar_len_o,
    output logic [2:0]                axi_ar_size_o,
    output logic [1:0]                axi_ar_burst_o,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user_o,

    input  logic                      axi_r_valid_i,
    output logic                      axi_r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
    input  logic [1:0]                axi_r_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i,
    input  logic                      axi_r_last_i
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t                    state_q, state_d;
    logic [RW_ADDR_WIDTH-1:0]  addr_q;
    logic [2:0]                size_q;
    logic [RW_DATA_WIDTH-1:0]  data_q;
    logic                      err_q;

    logic                      accept;
    logic                      beat;
    logic [2:0]                size_code;
    logic [OFF_W+2:0]          shamt;
    logic [AXI_DATA_WIDTH-1:0] shifted;
    logic [AXI_DATA_WIDTH-1:0] mask;
    logic [AXI_DATA_WIDTH-1:0] aligned;
    logic                      beat_err;
    logic                      unused_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rw_ready_o      = 1'b0;
        axi_ar_valid_o  = 1'b0;
        axi_r_ready_o   = 1'b0;
        rw_data_valid_o = 1'b0;
        accept          = 1'b0;
        beat            = 1'b0;
        case (state_q)
            IDLE: begin
                rw_ready_o = 1'b1;
                if (rw_valid_i) begin
                    accept  = 1'b1;
                    state_d = AR;
                end
            end
            AR: begin
                axi_ar_valid_o = 1'b1;
                if (axi_ar_ready_i) begin
                    state_d = R;
                end
            end
            R: begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i) begin
                    beat    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                rw_data_valid_o = 1'b1;
                if (rw_data_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unsupported byte counts fall back to a full 8-byte read.
    always_comb begin
        case (rw_size_i)
            8'd1:    size_code = 3'd0;
            8'd2:    size_code = 3'd1;
            8'd4:    size_code = 3'd2;
            default: size_code = 3'd3;
        endcase
    end

    always_comb begin
        shamt   = {addr_q[OFF_W-1:0], 3'b000};
        shifted = axi_r_data_i >> shamt;
        mask    = '0;
        for (int i = 0; i < BYTES; i++) begin
            mask[i*8 +: 8] = (i < (1 << size_q)) ? 8'hFF : 8'h00;
        end
        aligned  = shifted & mask;
        beat_err = (axi_r_resp_i != 2'b00) || (axi_r_id_i != AXI_ID_WIDTH'(AXI_ID));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            size_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= rw_addr_i;
                size_q <= size_code;
            end
            if (beat) begin
                data_q <= RW_DATA_WIDTH'(aligned);
                err_q  <= beat_err;
            end
        end
    end

    assign axi_ar_addr_o  = AXI_ADDR_WIDTH'(addr_q);
    assign axi_ar_size_o  = size_q;
    assign axi_ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign axi_ar_len_o   = 8'd0;
    assign axi_ar_burst_o = 2'b01;
    assign axi_ar_user_o  = '0;
    assign rw_data_o      = data_q;
    assign rw_resp_err_o  = err_q;

    // RLAST carries no information for a single-beat read.
    assign unused_last = axi_r_last_i;

endmodule
